hack_screen_scanner: RTL and testbench

- Display-side reader of the 8K-word screen memory. The CPU writes that memory through the data-memory map; this block is the other end of it.
- Walks the 512x256 Hack bitmap in raster order, issuing one read per 16-pixel word.
- Serialises each word LSB-first (bit 0 = leftmost pixel) and generates active-low hsync/vsync plus data-enable for a VGA-style sink.
- Runs at one pixel per clock, with no CPU-side involvement.

---
 rtl/hack_screen_scanner.sv | 114 +++++++++++
 tb/tb_hack_screen_scanner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hack_screen_scanner.sv
// rtl/hack_screen_scanner.sv - raster scanner for the 512x256 Hack screen memory with VGA-style timing
module hack_screen_scanner #(
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [12:0] scr_addr,
    output logic        scr_rd,
    input  logic [15:0] scr_data,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL = 512 + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = 256 + V_FRONT + V_SYNC + V_BACK;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_PRE  = XW'(H_TOTAL - 2);
    localparam logic [XW-1:0] X_ACT  = XW'(512);
    localparam logic [XW-1:0] X_FEND = XW'(496);
    localparam logic [XW-1:0] X_HS0  = XW'(512 + H_FRONT);
    localparam logic [XW-1:0] X_HS1  = XW'(512 + H_FRONT + H_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT  = YW'(256);
    localparam logic [YW-1:0] Y_VS0  = YW'(256 + V_FRONT);
    localparam logic [YW-1:0] Y_VS1  = YW'(256 + V_FRONT + V_SYNC);

    logic [XW-1:0] x, nx;
    logic [YW-1:0] y, ny, next_row;
    logic          run;
    logic          rd_d;
    logic [15:0]   sh;
    logic          nde;
    logic          fetch;
    logic [12:0]   faddr;
    logic [4:0]    fword;

    // The first cycle after reset holds position so the row-0 fetch is issued there.
    always_comb begin
        nx = x;
        ny = y;
        if (run) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                nx = x + 1'b1;
            end
        end
    end

    always_comb begin
        nde      = (nx < X_ACT) && (ny < Y_ACT);
        next_row = (ny == Y_LAST) ? '0 : ny + 1'b1;
        fword    = nx[8:4] + 5'd1;
        fetch    = 1'b0;
        faddr    = scr_addr;
        // Word 0 is fetched two cycles before the line starts, for the upcoming row.
        if (nx == X_PRE) begin
            if (next_row < Y_ACT) begin
                fetch = 1'b1;
                faddr = {next_row[7:0], 5'd0};
            end
        end else if ((nx[3:0] == 4'd14) && (nx < X_FEND) && (ny < Y_ACT)) begin
            fetch = 1'b1;
            faddr = {ny[7:0], fword};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            x           <= X_PRE;
            y           <= Y_LAST;
            run         <= 1'b0;
            rd_d        <= 1'b0;
            sh          <= '0;
            pixel       <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            scr_rd      <= 1'b0;
            scr_addr    <= '0;
            frame_start <= 1'b0;
        end else begin
            x           <= nx;
            y           <= ny;
            run         <= 1'b1;
            de          <= nde;
            hsync       <= !((nx >= X_HS0) && (nx < X_HS1));
            vsync       <= !((ny >= Y_VS0) && (ny < Y_VS1));
            frame_start <= (nx == '0) && (ny == '0);
            scr_rd      <= fetch;
            scr_addr    <= faddr;
            rd_d        <= scr_rd;
            // Read data arrives the cycle after the strobe; its bit 0 is shown immediately.
            if (rd_d) begin
                sh    <= scr_data >> 1;
                pixel <= scr_data[0] & nde;
            end else begin
                sh    <= sh >> 1;
                pixel <= sh[0] & nde;
            end
        end
    end
endmodule

// File: tb/tb_hack_screen_scanner.sv
// tb/tb_hack_screen_scanner.sv - randomized bench with a position-level reference model
module tb_hack_screen_scanner;
    localparam int HF = 2, HS = 2, HB = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = 512 + HF + HS + HB;
    localparam int VT = 256 + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] scr_addr;
    logic        scr_rd;
    logic [15:0] scr_data = 16'h0;
    logic        pixel, de, hsync, vsync, frame_start;

    logic [15:0] mem [8192];

    int errors = 0;
    int checks = 0;

    int  mx = 0, my = 0, m_addr = 0;
    bit  m_rst = 1'b0, m_valid = 1'b0;
    int  rd_count = 0, blank_count = 0;
    bit  armed = 1'b0;

    hack_screen_scanner #(
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clk),
        .reset(reset),
        .scr_addr(scr_addr),
        .scr_rd(scr_rd),
        .scr_data(scr_data),
        .pixel(pixel),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory; garbage on the bus whenever no read is pending.
    always @(posedge clk) begin
        if (scr_rd) scr_data <= mem[scr_addr];
        else        scr_data <= 16'($urandom);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)", name, act, exp, mx, my, $time);
        end
    endtask

    // Address fetched at screen position (x,y), or -1 when that cycle has no read.
    function automatic int fetch_addr(input int x, input int y);
        for (int w = 0; w < 32; w++) begin
            int row;
            row = (w == 0) ? (y + 1) % VT : y;
            if (x == (16 * w - 2 + HT) % HT && row < 256) return row * 32 + w;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int a;
        if (!reset) begin
            m_rst = 1'b1; m_valid = 1'b1;
            mx = HT - 2; my = VT - 1; m_addr = 0;
        end else if (m_valid) begin
            if (m_rst) begin
                m_rst = 1'b0;
            end else begin
                mx = mx + 1;
                if (mx == HT) begin
                    mx = 0;
                    my = (my + 1) % VT;
                end
            end
            a = fetch_addr(mx, my);
            if (a >= 0) m_addr = a;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_rst) begin
                chk("rst_pixel", int'(pixel), 0);
                chk("rst_de", int'(de), 0);
                chk("rst_hsync", int'(hsync), 1);
                chk("rst_vsync", int'(vsync), 1);
                chk("rst_rd", int'(scr_rd), 0);
                chk("rst_addr", int'(scr_addr), 0);
                chk("rst_fs", int'(frame_start), 0);
                rd_count = 0; blank_count = 0; armed = 1'b0;
            end else begin
                logic [15:0] wv;
                int e_de, e_px;
                e_de = (mx < 512 && my < 256) ? 1 : 0;
                wv   = mem[(my % 256) * 32 + (mx % 512) / 16];
                e_px = e_de ? int'(wv[mx % 16]) : 0;
                if (mx == 0 && my == 0) begin
                    if (armed) begin
                        chk("reads_per_frame", rd_count, 8192);
                        chk("blank_reads", blank_count, 1);
                    end
                    armed = 1'b1; rd_count = 0; blank_count = 0;
                end
                if (scr_rd) begin
                    rd_count++;
                    if (my >= 256) blank_count++;
                end
                chk("rd", int'(scr_rd), fetch_addr(mx, my) >= 0 ? 1 : 0);
                chk("addr", int'(scr_addr), m_addr);
                chk("de", int'(de), e_de);
                chk("hsync", int'(hsync), (mx >= 512 + HF && mx < 512 + HF + HS) ? 0 : 1);
                chk("vsync", int'(vsync), (my >= 256 + VF && my < 256 + VF + VS) ? 0 : 1);
                chk("frame_start", int'(frame_start), (mx == 0 && my == 0) ? 1 : 0);
                chk("pixel", int'(pixel), e_px);
                if (mx == HT - 2 && my == 0) chk("row1_start", int'(scr_addr), 32);
                if (mx == 494 && my == 255) begin
                    chk("last_rd", int'(scr_rd), 1);
                    chk("last_addr", int'(scr_addr), 8191);
                end
            end
        end
    end

    task automatic wait_pos(input int x, input int y, input int budget, input string name);
        int n;
        n = 0;
        while (!(mx == x && my == y && !m_rst)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                chk(name, 0, 1);
                return;
            end
        end
    endtask

    // Called at the negedge right after the release edge.
    task automatic check_release(input string tag);
        chk({tag, "_rd"}, int'(scr_rd), 1);
        chk({tag, "_addr"}, int'(scr_addr), 0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_fs"}, int'(frame_start), 1);
        chk({tag, "_de"}, int'(de), 1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_release("start");
        chk("px_x0", int'(pixel), 1);
        for (int x = 1; x < 32; x++) begin
            @(negedge clk);
            chk("px_order", int'(pixel), (x == 31) ? 1 : 0);
        end
        wait_pos(0, 2, 2000, "timeout_a");

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(20, 900)) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            for (int j = 0; j < 8192; j++) mem[j] = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_release("rand_rel");
        end

        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8192; j++) mem[j] = {3'b111, 13'(j)};
        reset = 1'b1;
        @(negedge clk);
        check_release("addr_rel");
        wait_pos(200, 100, 60000, "timeout_mid");
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rd", int'(scr_rd), 0);
        chk("mid_hsync", int'(hsync), 1);
        reset = 1'b1;
        @(negedge clk);
        check_release("mid_rel");
        @(negedge clk);
        wait_pos(0, 0, 140000, "timeout_frame");
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
